// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding,
// sizing constants, the hold-timeout limit and the 3-to-8 one-hot decoder.
package rr_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_REQ    = 8;
    localparam int IDX_W    = 3;
    localparam int HOLD_MAX = 15;

    // 3-to-8 one-hot decoder with enable; all-zero output when disabled.
    function automatic logic [7:0] dec_3_8(input logic [2:0] sel, input logic en);
        logic [7:0] onehot;
        case (sel)
            3'd0:    onehot = 8'b0000_0001;
            3'd1:    onehot = 8'b0000_0010;
            3'd2:    onehot = 8'b0000_0100;
            3'd3:    onehot = 8'b0000_1000;
            3'd4:    onehot = 8'b0001_0000;
            3'd5:    onehot = 8'b0010_0000;
            3'd6:    onehot = 8'b0100_0000;
            3'd7:    onehot = 8'b1000_0000;
            default: onehot = 8'b0000_0000;
        endcase
        if (en) begin
            return onehot;
        end else begin
            return 8'b0000_0000;
        end
    endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Round-robin picker: finds the first set request at or above ptr, wrapping
// past 7 back to 0. Rotate so ptr lands on bit 0, priority-encode the lowest
// set bit, then add ptr back (mod 8) to recover the absolute index.
module rr_pick_8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl_s;
    logic [N_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]   off_s;

    // Rotate the request vector right by ptr so the search always starts at bit 0.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[N_REQ-1:0];
    end

    // Lowest-set-bit priority encoder over the rotated vector.
    always_comb begin
        off_s = 3'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = i[IDX_W-1:0];
            end else begin
                off_s = off_s;
            end
        end
    end

    // Undo the rotation; 3-bit addition wraps naturally.
    always_comb begin
        idx = off_s + ptr;
        any = |req;
    end

endmodule

// File: rtl/rr_arbiter_3_8.sv
// Round-robin arbiter sharing one 3-to-8 decoded resource among 8 requesters.
// A grant is held until the owner pulses done or drops its request; every
// release is followed by one dead (bus-turnaround) cycle in IDLE.
// Optional build macro RR_ARB_HOLD_TIMEOUT_EN: force-release an owner after
// HOLD_MAX grant cycles.
module rr_arbiter_3_8
    import rr_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             busy_err
);

    state_t           state_r, state_s;
    logic [IDX_W-1:0] ptr_r, ptr_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic             valid_r, valid_s;
    logic [N_REQ-1:0] gnt_r, gnt_s;
    logic             err_r, err_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic             owner_req_s;
    logic             timeout_s;
    logic             release_s;

    rr_pick_8 u_pick (
        .req (req),
        .ptr (ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

`ifdef RR_ARB_HOLD_TIMEOUT_EN
    logic [3:0] hold_cnt_r, hold_cnt_s;

    // Hold counter: zero while idle (so it is clear on GRANT entry), counts GRANT cycles.
    always_comb begin
        if (state_r == GRANT) begin
            hold_cnt_s = hold_cnt_r + 4'd1;
            timeout_s  = (hold_cnt_r == 4'(HOLD_MAX - 1));
        end else begin
            hold_cnt_s = 4'd0;
            timeout_s  = 1'b0;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= 4'd0;
        end else begin
            hold_cnt_r <= hold_cnt_s;
        end
    end
`else
    // Without the timeout an owner may hold the grant indefinitely.
    always_comb begin
        timeout_s = 1'b0;
    end
`endif

    // Release conditions for the current owner; done and a dropped request together count once.
    always_comb begin
        owner_req_s = req[idx_r];
        release_s   = done | ~owner_req_s | timeout_s;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        idx_s   = idx_r;
        valid_s = valid_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (done) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (pick_any_s) begin
                    state_s = GRANT;
                    idx_s   = pick_idx_s;
                    valid_s = 1'b1;
                end else begin
                    idx_s   = 3'd0;
                    valid_s = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_s = IDLE;
                    ptr_s   = idx_r + 3'd1;
                    idx_s   = 3'd0;
                    valid_s = 1'b0;
                end else begin
                    state_s = GRANT;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 3'd0;
                valid_s = 1'b0;
            end
        endcase
        gnt_s = dec_3_8(idx_s, valid_s);
    end

    // State and registered outputs; reset drops any grant asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= 3'd0;
            idx_r   <= 3'd0;
            valid_r <= 1'b0;
            gnt_r   <= 8'h00;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            idx_r   <= idx_s;
            valid_r <= valid_s;
            gnt_r   <= gnt_s;
            err_r   <= err_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = idx_r;
    assign gnt_valid = valid_r;
    assign busy_err  = err_r;

endmodule

// File: tb/tb_rr_arbiter_3_8.sv
// Self-checking bench for rr_arbiter_3_8: a vector table replayed through a
// scoreboard queue, plus hand-written async-reset and long-hold sequences.
module tb_rr_arbiter_3_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       busy_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       err;
    } out_t;

    typedef struct {
        logic [7:0] req;
        logic       done;
        out_t       exp;
    } vec_t;

    localparam int NV = 34;
    vec_t tbl[NV];
    out_t sb_q[$];

    always #5 clk = ~clk;

    rr_arbiter_3_8 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy_err  (busy_err)
    );

    function automatic vec_t mk(input logic [7:0] r, input logic d, input logic [7:0] g,
                                input logic [2:0] ix, input logic v, input logic e);
        vec_t t;
        t.req  = r;
        t.done = d;
        t.exp  = '{gnt: g, idx: ix, valid: v, err: e};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input out_t e);
        out_t a;
        a = '{gnt: gnt, idx: gnt_idx, valid: gnt_valid, err: busy_err};
        check(name, 32'(a), 32'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        out_t e;

        // req, done -> gnt, idx, valid, err after the next edge
        tbl[0]  = mk(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0); // first grant, 1-cycle latency
        tbl[1]  = mk(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0); // hold
        tbl[2]  = mk(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0); // release, ptr=3
        tbl[3]  = mk(8'hFF, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        tbl[4]  = mk(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        tbl[5]  = mk(8'hFF, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
        tbl[6]  = mk(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        tbl[7]  = mk(8'hFF, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
        tbl[8]  = mk(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        tbl[9]  = mk(8'hFF, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);
        tbl[10] = mk(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        tbl[11] = mk(8'hFF, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        tbl[12] = mk(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0); // ptr wraps to 0
        tbl[13] = mk(8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        tbl[14] = mk(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        tbl[15] = mk(8'hFF, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        tbl[16] = mk(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        tbl[17] = mk(8'hFF, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
        tbl[18] = mk(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0); // ptr=3
        tbl[19] = mk(8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0); // 3..7 -> 7
        tbl[20] = mk(8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0); // ptr 7 -> 0
        tbl[21] = mk(8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0); // wrap-around pick
        tbl[22] = mk(8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0); // ptr=1
        tbl[23] = mk(8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0); // owner 5
        tbl[24] = mk(8'hE0, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0); // non-owner requests ignored
        tbl[25] = mk(8'hC0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0); // owner withdraws, ptr=6
        tbl[26] = mk(8'hC0, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0); // next above 5
        tbl[27] = mk(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0); // withdraw, ptr=7
        tbl[28] = mk(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0); // idle stays zero
        tbl[29] = mk(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1); // done in IDLE
        tbl[30] = mk(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1); // sticky
        tbl[31] = mk(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b1); // 7,0,1 -> 1
        tbl[32] = mk(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1); // done + drop = one release, ptr=2
        tbl[33] = mk(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b1); // 2..7,0,1 -> 1

        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        #2;
        check_out("reset_async", '{gnt: 8'h00, idx: 3'd0, valid: 1'b0, err: 1'b0});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_out("reset_state", '{gnt: 8'h00, idx: 3'd0, valid: 1'b0, err: 1'b0});

        for (int i = 0; i < NV; i++) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            sb_q.push_back(tbl[i].exp);
            tick();
            e = sb_q.pop_front();
            check_out($sformatf("vec%0d", i), e);
        end
        done = 1'b0;

        // Reset mid-grant (owner 1, ptr=2) between clock edges.
        req = 8'h0A;
        #2;
        rst = 1'b1;
        #1;
        check_out("rst_mid_grant", '{gnt: 8'h00, idx: 3'd0, valid: 1'b0, err: 1'b0});
        #1;
        rst = 1'b0;
        tick();
        check_out("ptr_after_rst", '{gnt: 8'h02, idx: 3'd1, valid: 1'b1, err: 1'b0});

        // Long hold by owner 0 with no done.
        rst = 1'b1;
        req = 8'h03;
        #1;
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (gnt == 8'h01) begin
                n++;
            end else begin
                break;
            end
        end
`ifdef RR_ARB_HOLD_TIMEOUT_EN
        check("hold_cycles", 32'(n), 32'd15);
        check_out("timeout_dead", '{gnt: 8'h00, idx: 3'd0, valid: 1'b0, err: 1'b0});
        tick();
        check_out("timeout_next", '{gnt: 8'h02, idx: 3'd1, valid: 1'b1, err: 1'b0});
`else
        check("hold_cycles", 32'(n), 32'd40);
        check_out("hold_owner", '{gnt: 8'h01, idx: 3'd0, valid: 1'b1, err: 1'b0});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_3_8.md
Name: rr_arbiter_3_8

Overview:
- Round-robin arbiter that shares one 3-to-8 one-hot decoded resource between 8 requesters.
- It grants exactly one requester at a time and holds the grant until that owner releases it.
- Its outputs are a registered one-hot grant vector and the encoded owner index, which drives the 3-to-8 decoder select and enable inputs.
- It sits between 8 client blocks and the shared decoder/bus it controls.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8; index width is 3.
- HOLD_MAX, 15, maximum cycles one owner may hold the grant. Used only with the optional feature.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request vector; req[i]=1 means requester i wants the resource.
- done  input  1  release strobe from the current owner; one-cycle pulse.
- gnt  output  8  registered one-hot grant, 0 when no owner.
- gnt_idx  output  3  encoded index of the owner; 0 when no owner.
- gnt_valid  output  1  1 while an owner holds the resource.
- busy_err  output  1  sticky error flag; set when done is asserted with no owner.

Behaviour:
- Reset (async, rst=1):
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, busy_err=0.
  - Round-robin pointer ptr=3'd0; state=IDLE.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first set bit starting at ptr and searching upward with wrap-around (ptr, ptr+1, ..., 7, 0, ..., ptr-1).
  - Next edge: gnt=1<<idx, gnt_idx=idx, gnt_valid=1, state=GRANT.
  - Latency from req sampled to gnt visible: 1 cycle.
  - If req==0, stay in IDLE; all outputs stay 0.
- GRANT:
  - Grant holds while req[gnt_idx]=1 and done=0.
  - Release happens when done=1, or when req[gnt_idx]=0 (owner withdrew).
  - On release, next edge: gnt=0, gnt_valid=0, gnt_idx=0, ptr=gnt_idx+1 (mod 8, so 7 wraps to 0), state=IDLE.
  - This gives exactly one dead cycle between owners. That cycle is the guaranteed bus-turnaround cycle.
- Requests from non-owners during GRANT are ignored; they are re-evaluated in the IDLE cycle.
- done asserted in IDLE: busy_err sets to 1 and stays 1 until reset. No other effect.
- done and owner req drop in the same cycle: treated as one release.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt==(gnt_valid ? 1<<gnt_idx : 0).
- Fairness: a continuously requesting client is granted within 7 grant periods.

Optional Feature:
- Macro: RR_ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A 4-bit hold counter clears on entry to GRANT and increments every GRANT cycle.
  - When the counter reaches HOLD_MAX with no release, the arbiter force-releases as if done=1: ptr advances past the owner and state returns to IDLE.
  - The owner can be re-granted only after ptr wraps.
- Not defined: no counter logic exists, and an owner may hold the grant indefinitely.

Decomposition:
- Shared package rr_arb_pkg:
  - state enum {IDLE, GRANT}.
  - N_REQ=8 and IDX_W=3 constants.
  - HOLD_MAX default.
- One sub-module, rr_pick_8 (purely combinational):
  - Inputs req[7:0] and ptr[2:0].
  - Outputs idx[2:0] and any.
  - Implemented as rotate, priority encode, then add ptr back.
- The one-hot gnt is produced from idx through the team's existing 2-to-4/3-to-8 decoder, with enable tied to the registered valid.

Test Plan:
- Reset, then req=8'b0000_0100 → next cycle gnt=8'h04, gnt_idx=2, gnt_valid=1; gnt stays 8'h04 while req holds and done=0.
- Owner 2 granted, req=8'hFF held, pulse done → one idle cycle, then gnt=8'h08 (idx 3); repeat done pulses → sequence 3,4,5,6,7,0,1,2.
- ptr=7, req=8'b1000_0001 → grant idx 7; after release grant idx 0 (wrap-around).
- Owner 5 drops req[5] without done → next edge gnt=0; after the dead cycle, the next requester above 5 is granted.
- done pulse while IDLE → busy_err=1 and stays 1; assert rst mid-GRANT → gnt=0 and busy_err=0 immediately, without waiting for a clock edge.
- With RR_ARB_HOLD_TIMEOUT_EN defined and HOLD_MAX=15, req=8'h03 held with no done → owner 0 force-released after 15 GRANT cycles, then owner 1 granted.
